// File: rtl/pnc_stmc_pkg.sv
// Shared encodings for the PNC spike/parameter dispatch unit: beat control codes,
// FSM state constants and a saturating counter helper.
package pnc_stmc_pkg;

  localparam logic [1:0] CTRL_IDLE  = 2'b00;
  localparam logic [1:0] CTRL_TGT   = 2'b01;
  localparam logic [1:0] CTRL_BCAST = 2'b10;
  localparam logic [1:0] CTRL_PDATA = 2'b11;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_PARAM = 2'd1;
  localparam state_t ST_BCAST = 2'd2;

  function automatic logic [7:0] satInc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/pnc_stmc_fifo.sv
// Synchronous FIFO buffering incoming address words; pointers carry an extra wrap
// bit so full and empty can be told apart without a separate counter.
module pnc_stmc_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wrPtr;
  logic [AW:0]      rdPtr;
  logic             doPush;
  logic             doPop;

  assign doPush = push && !full;
  assign doPop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PTR_ONE;
      if (doPop)  rdPtr <= rdPtr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rdPtr[AW-1:0]];
  assign empty = (wrPtr == rdPtr);
  assign full  = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);

endmodule

// File: rtl/pnc_stmc_dispatch.sv
// Dispatch control: classifies buffered address words and emits targeted, broadcast
// or parameter-data beats on a registered valid/ready output, with packet counters.
module pnc_stmc_dispatch
  import pnc_stmc_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int NUM_CH      = 4,
  parameter int FIFO_DEPTH  = 4,
  parameter int PARAM_WORDS = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      iValid,
  input  logic [ADDR_W-1:0]         iAddr,
  output logic                      oReady,
  output logic                      oValid,
  input  logic                      iReady,
  output logic [1:0]                oCtrl,
  output logic [$clog2(NUM_CH)-1:0] oChSel,
  output logic [ADDR_W-1:0]         oPayload,
  output logic [15:0]               oSpikeCnt,
  output logic [7:0]                oParamCnt
);

  localparam int CH_W  = $clog2(NUM_CH);
  localparam int REM_W = $clog2(PARAM_WORDS + 1);
  localparam logic [CH_W-1:0]  CH_LAST   = CH_W'(NUM_CH - 1);
  localparam logic [CH_W-1:0]  CH_ONE    = CH_W'(1);
  localparam logic [REM_W-1:0] REM_ONE   = REM_W'(1);
  localparam logic [REM_W-1:0] REM_START = REM_W'(PARAM_WORDS);

  logic [ADDR_W-1:0] headWord;
  logic              fifoFull;
  logic              fifoEmpty;
  logic              push;
  logic              pop;
  logic              advance;
  logic              isHeader;
  logic              isRich;
  state_t            state;
  logic [REM_W-1:0]  remain;
  logic [CH_W-1:0]   paramCh;
  logic [CH_W-1:0]   bcastCh;

  assign oReady   = !fifoFull;
  assign push     = iValid && oReady;
  assign advance  = !oValid || iReady;
  assign isHeader = headWord[ADDR_W-1];
  assign isRich   = headWord[ADDR_W-2];

  // A local spike stays at the FIFO head until its last broadcast beat is loaded.
  always_comb begin
    pop = 1'b0;
    if (advance && !fifoEmpty) begin
      case (state)
        ST_IDLE:  pop = isHeader || isRich;
        ST_PARAM: pop = 1'b1;
        ST_BCAST: pop = (bcastCh == CH_LAST);
        default:  pop = 1'b0;
      endcase
    end
  end

  pnc_stmc_fifo #(
    .WIDTH (ADDR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (iAddr),
    .rdata (headWord),
    .full  (fifoFull),
    .empty (fifoEmpty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      remain    <= '0;
      paramCh   <= '0;
      bcastCh   <= '0;
      oValid    <= 1'b0;
      oCtrl     <= CTRL_IDLE;
      oChSel    <= '0;
      oPayload  <= '0;
      oSpikeCnt <= '0;
      oParamCnt <= '0;
    end else if (advance) begin
      case (state)
        ST_IDLE: begin
          if (!fifoEmpty) begin
            oValid   <= 1'b1;
            oPayload <= headWord;
            if (isHeader) begin
              oCtrl     <= CTRL_TGT;
              oChSel    <= headWord[CH_W-1:0];
              paramCh   <= headWord[CH_W-1:0];
              remain    <= REM_START;
              oParamCnt <= satInc8(oParamCnt);
              state     <= ST_PARAM;
            end else if (isRich) begin
              oCtrl     <= CTRL_TGT;
              oChSel    <= headWord[CH_W-1:0];
              oSpikeCnt <= oSpikeCnt + 16'd1;
            end else begin
              oCtrl   <= CTRL_BCAST;
              oChSel  <= '0;
              bcastCh <= CH_ONE;
              state   <= ST_BCAST;
            end
          end else begin
            oValid <= 1'b0;
            oCtrl  <= CTRL_IDLE;
          end
        end
        ST_PARAM: begin
          if (!fifoEmpty) begin
            oValid   <= 1'b1;
            oCtrl    <= CTRL_PDATA;
            oChSel   <= paramCh;
            oPayload <= headWord;
            remain   <= remain - REM_ONE;
            if (remain == REM_ONE) state <= ST_IDLE;
          end else begin
            oValid <= 1'b0;
            oCtrl  <= CTRL_IDLE;
          end
        end
        ST_BCAST: begin
          oValid   <= 1'b1;
          oCtrl    <= CTRL_BCAST;
          oChSel   <= bcastCh;
          oPayload <= headWord;
          if (bcastCh == CH_LAST) begin
            oSpikeCnt <= oSpikeCnt + 16'd1;
            state     <= ST_IDLE;
          end else begin
            bcastCh <= bcastCh + CH_ONE;
          end
        end
        default: begin
          state  <= ST_IDLE;
          oValid <= 1'b0;
          oCtrl  <= CTRL_IDLE;
        end
      endcase
    end
  end

endmodule
